// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle WIDTH-bit adder. Each clock adds BITS_PER_CYCLE operand bits,
//   LSB slice first, and chains the slices through a carry flop. Trades
//   latency (N = WIDTH/BITS_PER_CYCLE cycles) for a narrow adder.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     defined   -> extra input i_sub; i_sub=1 computes A-B (o_carry=1 means no borrow)
//     undefined -> add only, initial carry always 0
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     request, sampled only in IDLE
//   i_a, i_b    operands, captured on the accepted i_start edge
//   i_sub       (SERIAL_ADDER_SUB_EN only) subtract select, captured with operands
//   o_busy      high while slices are being added
//   o_done      one-cycle result-valid pulse
//   o_sum       result, held until the next completion
//   o_carry     carry out of the MSB
//   o_overflow  signed overflow of the operation
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for i_start
//   RUN    | adding one slice per clock
//   DONE   | result registered, o_done pulse

module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || B < 1 || (WIDTH % B) != 0) begin : g_bad_cfg
      $fatal(1, "serial_adder: BITS_PER_CYCLE must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr, b_sr, sum_sr;
  logic               carry_q;
  logic [CNT_W-1:0]   count_q;

  logic [WIDTH-1:0]   b_load;
  logic               cin_load;
  logic [B:0]         slice_sum;
  logic [WIDTH-1:0]   sum_next;
  logic               last_slice;
  logic               ovf_next;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: A + ~B + 1.
  assign b_load   = i_sub ? ~i_b : i_b;
  assign cin_load = i_sub;
`else
  assign b_load   = i_b;
  assign cin_load = 1'b0;
`endif

  assign slice_sum = {1'b0, a_sr[B-1:0]} + {1'b0, b_sr[B-1:0]} + {{B{1'b0}}, carry_q};

  // Slice results enter at the top so that after N shifts the LSB slice
  // has walked down to bit 0.
  generate
    if (N == 1) begin : g_single
      assign sum_next = slice_sum[B-1:0];
    end else begin : g_multi
      assign sum_next = {slice_sum[B-1:0], sum_sr[WIDTH-1:B]};
    end
  endgenerate

  assign last_slice = (count_q == CNT_W'(N - 1));

  // On the last slice the operand MSBs sit at bit B-1 of the shift regs;
  // b_sr already holds the effective (possibly inverted) B.
  assign ovf_next = (a_sr[B-1] == b_sr[B-1]) && (slice_sum[B-1] != a_sr[B-1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      sum_sr     <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            a_sr    <= i_a;
            b_sr    <= b_load;
            carry_q <= cin_load;
            count_q <= '0;
          end
        end
        S_RUN: begin
          a_sr    <= a_sr >> B;
          b_sr    <= b_sr >> B;
          sum_sr  <= sum_next;
          carry_q <= slice_sum[B];
          count_q <= count_q + CNT_W'(1);
          if (last_slice) begin
            o_sum      <= sum_next;
            o_carry    <= slice_sum[B];
            o_overflow <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state_q == S_RUN);
  assign o_done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done, carry, ovf;
  logic [7:0]  sum;

  logic        start16;
  logic [15:0] a16, b16;
  logic        busy16, done16, carry16, ovf16;
  logic [15:0] sum16;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub, sub16;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] held_sum;
  logic       held_c, held_o;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(sub),
`endif
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_carry(carry), .o_overflow(ovf)
  );

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_a(a16), .i_b(b16),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub(sub16),
`endif
    .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_carry(carry16), .o_overflow(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".sum"},  32'(sum),  32'd0);
    check({tag, ".carry"}, 32'(carry), 32'd0);
    check({tag, ".ovf"},  32'(ovf),  32'd0);
  endtask

  // Reference: whole-word arithmetic, b' = ~b and carry-in 1 for subtract.
  task automatic run8(input logic [7:0] ain, input logic [7:0] bin, input logic sin,
                      input bit inject, input string tag);
    logic [7:0] bb, es;
    logic [8:0] full;
    logic       ec, eo;
    bb   = sin ? ~bin : bin;
    full = {1'b0, ain} + {1'b0, bb} + {8'd0, sin};
    es   = full[7:0];
    ec   = full[8];
    eo   = (ain[7] == bb[7]) && (es[7] != ain[7]);
    @(negedge clk);
    a = ain; b = bin;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sin;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check({tag, ".run_busy"}, 32'(busy), 32'd1);
      check({tag, ".run_done"}, 32'(done), 32'd0);
      if (k == 4) begin
        check({tag, ".hold_sum"}, 32'(sum), 32'(held_sum));
        check({tag, ".hold_c"},   32'(carry), 32'(held_c));
        check({tag, ".hold_o"},   32'(ovf), 32'(held_o));
      end
      if (inject && k == 2) start = 1'b1;
      if (inject && k == 3) start = 1'b0;
    end
    @(negedge clk);
    check({tag, ".done"},  32'(done),  32'd1);
    check({tag, ".busy"},  32'(busy),  32'd0);
    check({tag, ".sum"},   32'(sum),   32'(es));
    check({tag, ".carry"}, 32'(carry), 32'(ec));
    check({tag, ".ovf"},   32'(ovf),   32'(eo));
    held_sum = es; held_c = ec; held_o = eo;
    @(negedge clk);
    check({tag, ".post_done"}, 32'(done), 32'd0);
    check({tag, ".post_busy"}, 32'(busy), 32'd0);
    check({tag, ".post_sum"},  32'(sum),  32'(es));
  endtask

  task automatic run16(input logic [15:0] ain, input logic [15:0] bin, input logic sin,
                       input string tag);
    logic [15:0] bb, es;
    logic [16:0] full;
    logic        eo;
    bb   = sin ? ~bin : bin;
    full = {1'b0, ain} + {1'b0, bb} + {16'd0, sin};
    es   = full[15:0];
    eo   = (ain[15] == bb[15]) && (es[15] != ain[15]);
    @(negedge clk);
    a16 = ain; b16 = bin;
`ifdef SERIAL_ADDER_SUB_EN
    sub16 = sin;
`endif
    start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, ".run_busy"}, 32'(busy16), 32'd1);
      check({tag, ".run_done"}, 32'(done16), 32'd0);
    end
    @(negedge clk);
    check({tag, ".done"},  32'(done16),  32'd1);
    check({tag, ".sum"},   32'(sum16),   32'(es));
    check({tag, ".carry"}, 32'(carry16), 32'(full[16]));
    check({tag, ".ovf"},   32'(ovf16),   32'(eo));
  endtask

  initial begin
    logic       rs;
    logic [7:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0; sub16 = 1'b0;
`endif
    held_sum = '0; held_c = 1'b0; held_o = 1'b0;

    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_reset");
    repeat (5) @(negedge clk);
    check_zero("idle_5");

    run8(8'h0F, 8'h01, 1'b0, 1'b0, "add_0f_01");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    run8(8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
    run8(8'h80, 8'h80, 1'b0, 1'b0, "add_80_80");
    run8(8'h3C, 8'h5A, 1'b0, 1'b1, "inject");

    // Start held high: DONE ignores it, the following IDLE edge accepts.
    @(negedge clk);
    a = 8'h21; b = 8'h12; start = 1'b1;
    @(posedge clk);
    #1;
    repeat (9) @(negedge clk);
    check("held.done1", 32'(done), 32'd1);
    check("held.sum1",  32'(sum),  32'h33);
    @(negedge clk);
    check("held.gap_busy", 32'(busy), 32'd0);
    check("held.gap_done", 32'(done), 32'd0);
    a = 8'h40; b = 8'h02;
    @(negedge clk);
    check("held.reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("held.done2", 32'(done), 32'd1);
    check("held.sum2",  32'(sum),  32'h42);
    held_sum = 8'h42; held_c = 1'b0; held_o = 1'b0;

    // Reset in cycle 4 of RUN discards everything.
    @(negedge clk);
    a = 8'hAA; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    held_sum = '0; held_c = 1'b0; held_o = 1'b0;
    run8(8'h12, 8'h34, 1'b0, 1'b0, "after_mid_reset");

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run8(ra, rb, rs, 1'b0, "rand");
    end

`ifdef SERIAL_ADDER_SUB_EN
    run8(8'h05, 8'h07, 1'b1, 1'b0, "sub_05_07");
    run8(8'h80, 8'h01, 1'b1, 1'b0, "sub_80_01");
    run8(8'h07, 8'h05, 1'b1, 1'b0, "sub_07_05");
    run16(16'h1234, 16'h1234, 1'b1, "w16_sub");
`endif

    run16(16'h1234, 16'hEDCC, 1'b0, "w16_1234_edcc");
    run16(16'h7FF0, 16'h0010, 1'b0, "w16_ovf");
    run16(16'($urandom), 16'($urandom), 1'b0, "w16_rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
